// File: rtl/mem_readout_pkg.sv
// mem_readout_pkg
//   Shared declarations for the BRAM block-readout sequencer:
//   - state_t : sequencer FSM states
//   - NENT_W  : width of the entry count taken from the BRAM nent_0 output
//   - clogb2  : address width needed for a given BRAM depth
package mem_readout_pkg;

  localparam int NENT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of address bits needed to index 'depth' entries (1024 -> 10).
  function automatic int clogb2(input int depth);
    int d;
    int r;
    d = depth - 1;
    r = 0;
    while (d > 0) begin
      r++;
      d = d >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_readout_if.sv
// mem_readout_if
//   Bus bundle for mem_readout.
//   BRAM read port : addrb, enb, regceb (sequencer -> BRAM), doutb (BRAM -> sequencer)
//   Output stream  : m_data, m_valid, m_last (sequencer -> sink), m_ready (sink -> sequencer)
//   master modport : the sequencer side; slave modport : the BRAM/sink side.
interface mem_readout_if #(
  parameter int ADDR_W    = 10,
  parameter int RAM_WIDTH = 18
);

  logic [ADDR_W-1:0]    addrb;
  logic                 enb;
  logic                 regceb;
  logic [RAM_WIDTH-1:0] doutb;

  logic [RAM_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (
    output addrb, enb, regceb, m_data, m_valid, m_last,
    input  doutb, m_ready
  );

  modport slave (
    input  addrb, enb, regceb, m_data, m_valid, m_last,
    output doutb, m_ready
  );

endinterface

// File: rtl/mem_readout_fifo.sv
// readout_fifo
//   Small synchronous show-ahead FIFO that absorbs the BRAM read latency.
//   Ports:
//     clkb, rstb : clock, synchronous active-high reset (empties the FIFO)
//     push, din  : write an entry
//     pop        : remove the head entry (ignored when empty)
//     dout       : head entry, valid whenever empty=0
//     empty      : no entries stored
//     count      : number of stored entries (0..DEPTH)
//   The caller guarantees push never happens while full without a same-cycle pop.
module readout_fifo #(
  parameter  int WIDTH = 19,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clkb,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage carries no reset: validity is tracked by the pointers/count.
  always_ff @(posedge clkb) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clkb) begin
    if (rstb) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally so data is presented in the same cycle as !empty.
  assign dout  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/mem_readout.sv
// mem_readout
//   Read-side sequencer downstream of the page BRAM. A start pulse reads nent
//   words starting at base_addr through the BRAM registered read port and
//   presents them as a valid/ready stream with a last flag.
//   Ports:
//     clkb, rstb : clock, synchronous active-high reset
//     start      : one-cycle block request (only honoured in IDLE)
//     base_addr  : first BRAM address of the block
//     nent       : number of words in the block (0..31)
//     busy       : block in progress
//     done       : one-cycle pulse at block completion
//     bus        : BRAM read port + output stream (mem_readout_if.master)
module mem_readout
  import mem_readout_pkg::*;
#(
  parameter  int RAM_WIDTH    = 18,
  parameter  int RAM_DEPTH    = 1024,
  parameter  int READ_LATENCY = 2,
  parameter  int FIFO_DEPTH   = 4,
  localparam int ADDR_W       = clogb2(RAM_DEPTH)
) (
  input  logic              clkb,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NENT_W-1:0] nent,
  output logic              busy,
  output logic              done,
  mem_readout_if.master     bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IFL_W = $clog2(READ_LATENCY + 1);
  localparam int SUM_W = CNT_W + IFL_W;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [NENT_W-1:0] nent_reg, nent_next;
  logic [NENT_W-1:0] cnt_reg, cnt_next;

  logic              issue, issue_last, credit_ok;
  logic [IFL_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, pop;
  logic [RAM_WIDTH:0] fifo_head;

  // In-flight valid/last shift register, one stage per cycle of read latency.
  logic [READ_LATENCY-1:0] pipe_vld_reg, pipe_last_reg;
  logic [READ_LATENCY-1:0] vld_chain, last_chain;

  assign vld_chain[0]  = issue;
  assign last_chain[0] = issue_last;

  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
      assign vld_chain[gi]  = pipe_vld_reg[gi-1];
      assign last_chain[gi] = pipe_last_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clkb) begin
    if (rstb) begin
      pipe_vld_reg  <= '0;
      pipe_last_reg <= '0;
    end else begin
      pipe_vld_reg  <= vld_chain;
      pipe_last_reg <= last_chain;
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      inflight = inflight + IFL_W'(pipe_vld_reg[k]);
    end
  end

  // A pop in the same cycle is deliberately not credited, so the FIFO can
  // never be asked to accept more than FIFO_DEPTH outstanding words.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);

  always_ff @(posedge clkb) begin
    if (rstb) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      nent_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      nent_reg  <= nent_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    nent_next  = nent_reg;
    cnt_next   = cnt_reg;
    issue      = 1'b0;
    issue_last = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) begin
          base_next  = base_addr;
          nent_next  = nent;
          cnt_next   = '0;
          state_next = (nent == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (cnt_reg == nent_reg) begin
          state_next = DRAIN;
        end else if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (cnt_reg == nent_reg - NENT_W'(1));
          cnt_next   = cnt_reg + NENT_W'(1);
        end
      end
      DRAIN: begin
        if (pop && fifo_head[RAM_WIDTH]) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address wraps naturally at RAM_DEPTH through the ADDR_W-bit add.
  assign bus.enb    = issue;
  assign bus.addrb  = issue ? (base_reg + ADDR_W'(cnt_reg)) : '0;
  assign bus.regceb = 1'b1;

  // The word leaving the shift register is the one the BRAM is showing now.
  readout_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clkb  (clkb),
    .rstb  (rstb),
    .push  (pipe_vld_reg[READ_LATENCY-1]),
    .pop   (pop),
    .din   ({pipe_last_reg[READ_LATENCY-1], bus.doutb}),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop         = !fifo_empty && bus.m_ready;
  assign bus.m_valid = !fifo_empty;
  // Head is masked while empty so the stream outputs read 0 when idle.
  assign bus.m_data  = fifo_empty ? '0 : fifo_head[RAM_WIDTH-1:0];
  assign bus.m_last  = !fifo_empty && fifo_head[RAM_WIDTH];

endmodule

// File: tb/tb_mem_readout.sv
// tb_mem_readout
//   Directed, table-driven bench for mem_readout with a BRAM model whose
//   contents are mem[a] = a (READ_LATENCY = 2, registered output).
module tb_mem_readout;

  localparam int AW = 10;
  localparam int DW = 18;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [4:0]    nent;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  mem_readout_if #(.ADDR_W(AW), .RAM_WIDTH(DW)) bus ();

  mem_readout #(
    .RAM_WIDTH    (DW),
    .RAM_DEPTH    (1024),
    .READ_LATENCY (2),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clkb      (clk),
    .rstb      (rstb),
    .start     (start),
    .base_addr (base_addr),
    .nent      (nent),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: address register stage, then output register stage.
  logic [DW-1:0] bram_s1 = '0;
  initial bus.doutb = '0;
  always @(posedge clk) begin
    if (bus.enb) bram_s1 <= {8'h00, bus.addrb};
    if (bus.regceb) bus.doutb <= bram_s1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [4:0]    nent;
    int            lo_from;     // m_ready low for cycles lo_from..lo_to (-1: never)
    int            lo_to;
    int            restart_cyc; // cycle of a second start pulse (-1: none)
    logic [AW-1:0] rbase;
    logic [4:0]    rnent;
    int            exp_first_valid; // -1: m_valid never rises
    int            exp_done;
    int            exp_issued_lo;   // enb count by end of lo_to (-1: not checked)
  } vec_t;

  task automatic run_vec(input int id, input vec_t v);
    int cyc, ndone, first_v, done_c, issued, popped, max_out, issued_lo, stab_err;
    logic          hold_pend, hold_last, busy1;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] ea;
    logic [AW-1:0] addrs[$];
    logic [DW-1:0] datas[$];
    logic          lasts[$];
    ndone = 0; first_v = -1; done_c = -1; issued = 0; popped = 0;
    max_out = 0; issued_lo = -1; stab_err = 0; hold_pend = 1'b0;
    hold_last = 1'b0; hold_data = '0; busy1 = 1'b0;

    @(posedge clk); #1;
    cyc = 0;
    start = 1'b1; base_addr = v.base; nent = v.nent;
    bus.m_ready = !(cyc >= v.lo_from && cyc <= v.lo_to);
    while (cyc < 150) begin
      @(negedge clk);
      if (hold_pend && !(bus.m_valid && bus.m_data == hold_data && bus.m_last == hold_last))
        stab_err++;
      hold_pend = bus.m_valid && !bus.m_ready;
      hold_data = bus.m_data;
      hold_last = bus.m_last;
      if (bus.enb) begin
        addrs.push_back(bus.addrb);
        issued++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (bus.m_valid && first_v < 0) first_v = cyc;
      if (bus.m_valid && bus.m_ready) begin
        datas.push_back(bus.m_data);
        lasts.push_back(bus.m_last);
        popped++;
      end
      if (cyc == 1) busy1 = busy;
      if (cyc == v.lo_to) issued_lo = issued;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = cyc;
      end
      if (done_c >= 0 && cyc >= done_c + 3) break;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == v.restart_cyc) begin
        start = 1'b1; base_addr = v.rbase; nent = v.rnent;
      end
      bus.m_ready = !(cyc >= v.lo_from && cyc <= v.lo_to);
    end
    start = 1'b0;
    bus.m_ready = 1'b1;

    check($sformatf("v%0d issue_count", id), issued, int'(v.nent));
    check($sformatf("v%0d word_count", id), datas.size(), int'(v.nent));
    check($sformatf("v%0d first_valid_cycle", id), first_v, v.exp_first_valid);
    check($sformatf("v%0d done_cycle", id), done_c, v.exp_done);
    check($sformatf("v%0d done_pulses", id), ndone, 1);
    check($sformatf("v%0d busy_cycle1", id), int'(busy1), 1);
    check($sformatf("v%0d hold_stability", id), stab_err, 0);
    checks++;
    if (max_out > FD) begin
      errors++;
      $display("FAIL v%0d outstanding: got %0d expected at most %0d", id, max_out, FD);
    end
    if (v.exp_issued_lo >= 0)
      check($sformatf("v%0d issued_while_stalled", id), issued_lo, v.exp_issued_lo);
    for (int k = 0; k < int'(v.nent); k++) begin
      ea = v.base + AW'(k);
      if (k < addrs.size())
        check($sformatf("v%0d addrb[%0d]", id, k), int'(addrs[k]), int'(ea));
      if (k < datas.size()) begin
        check($sformatf("v%0d m_data[%0d]", id, k), int'(datas[k]), int'(ea));
        check($sformatf("v%0d m_last[%0d]", id, k), int'(lasts[k]), (k == int'(v.nent) - 1) ? 1 : 0);
      end
    end
    $display("block %0d base=0x%03h nent=%0d words=%0d first_valid=%0d done_cycle=%0d",
             id, v.base, v.nent, datas.size(), first_v, done_c);
    repeat (2) @(posedge clk);
  endtask

  vec_t vecs[7];
  vec_t v2;
  int   bad;

  initial begin
    // {base, nent, lo_from, lo_to, restart, rbase, rnent, first_valid, done, issued_lo}
    vecs[0] = '{10'h010, 5'd5,  -1, -1, -1, 10'h000, 5'd0, 4,  9,  -1};
    vecs[1] = '{10'h000, 5'd0,  -1, -1, -1, 10'h000, 5'd0, -1, 1,  -1};
    vecs[2] = '{10'h3FE, 5'd4,  -1, -1, -1, 10'h000, 5'd0, 4,  8,  -1};
    vecs[3] = '{10'h010, 5'd8,   4, 12, -1, 10'h000, 5'd0, 4,  21,  4};
    vecs[4] = '{10'h020, 5'd6,  -1, -1,  2, 10'h300, 5'd3, 4,  10, -1};
    vecs[5] = '{10'h123, 5'd1,  -1, -1, -1, 10'h000, 5'd0, 4,  5,  -1};
    vecs[6] = '{10'h3FF, 5'd31, -1, -1, -1, 10'h000, 5'd0, 4,  35, -1};

    rstb = 1'b1; start = 1'b0; base_addr = '0; nent = '0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset m_valid", int'(bus.m_valid), 0);
    check("reset m_data", int'(bus.m_data), 0);
    check("reset m_last", int'(bus.m_last), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset enb", int'(bus.enb), 0);
    check("reset addrb", int'(bus.addrb), 0);
    check("reset regceb", int'(bus.regceb), 1);
    $display("reset state m_valid=%0d busy=%0d enb=%0d regceb=%0d",
             bus.m_valid, busy, bus.enb, bus.regceb);
    @(posedge clk); #1;
    rstb = 1'b0; bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in cycle 3 of a 10-word block: everything in flight is dropped.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h100; nent = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;          // cycle 2
    @(posedge clk); #1;          // cycle 3
    rstb = 1'b1;
    @(posedge clk); #1;          // cycle 4
    rstb = 1'b0;
    @(negedge clk);
    check("midreset m_valid", int'(bus.m_valid), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.m_valid || done || busy || bus.enb) bad++;
    end
    check("midreset quiet", bad, 0);
    $display("mid-block reset aborted block, quiet cycles with activity=%0d", bad);

    v2 = '{10'h050, 5'd2, -1, -1, -1, 10'h000, 5'd0, 4, 6, -1};
    run_vec(7, v2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_readout.md
Name: mem_readout

Overview:
- Read-side sequencer that sits directly downstream of the page BRAM.
- On a start pulse it reads a block of entries from the BRAM through its registered read port, starting at a base address. The block length comes from the BRAM's entry-count output.
- It presents the words as a valid/ready stream with a last flag, and absorbs the BRAM read latency with a small credit-controlled FIFO.

Parameters:
- RAM_WIDTH, 18, data word width (matches BRAM).
- RAM_DEPTH, 1024, BRAM entries; ADDR_W = clogb2(RAM_DEPTH).
- READ_LATENCY, 2, BRAM read latency in cycles. 2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY.
- FIFO_DEPTH, 4, output buffer entries. Must be ≥ READ_LATENCY+2.

Ports:
- clkb  in  1  single clock (BRAM read clock).
- rstb  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to read a block.
- base_addr  in  ADDR_W  first BRAM address of the block.
- nent  in  5  entries to read, from BRAM nent_0.
- busy  out  1  block in progress.
- done  out  1  one-cycle pulse at block completion.
- addrb  out  ADDR_W  BRAM read address.
- enb  out  1  BRAM read enable.
- regceb  out  1  BRAM output register enable; tied to 1.
- doutb  in  RAM_WIDTH  BRAM read data.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of the block.

Behaviour:
- Reset (rstb=1 at an edge): all outputs are 0 except regceb=1.
  - FIFO emptied, in-flight pipeline cleared, state IDLE.
  - Reset mid-block aborts the block: no done pulse, and data already in flight is discarded.
- FSM states:
  - IDLE: on start=1, latch base_addr and nent, clear issue count i, then go to READ. If nent=0, go to DONE instead.
  - READ: issue reads until i==nent, then go to DRAIN.
  - DRAIN: wait until the last word has popped (m_valid & m_ready & m_last), then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in every state except IDLE. busy=1 in READ, DRAIN and DONE.
- Issue rule (READ): issue when fifo_count + inflight < FIFO_DEPTH.
  - Same-cycle pops are not credited.
  - Issuing means enb=1 and addrb = (base + i) mod RAM_DEPTH, with natural ADDR_W wrap. Then i++.
  - When not issuing, enb=0.
- In-flight tracking: a READ_LATENCY-deep valid shift register, carrying a last tag on the word issued with i==nent-1.
  - The tag leaves the shift register in the cycle doutb holds the issued word.
  - doutb and the last tag are pushed into the FIFO at that cycle's edge.
- Latency, with start in cycle 0:
  - First enb in cycle 1.
  - With READ_LATENCY=2, doutb is valid in cycle 3 and m_valid first rises in cycle 4.
  - With READ_LATENCY=1, m_valid first rises in cycle 3.
- Throughput: 1 word/cycle when m_ready is held high.
- FIFO:
  - m_valid = !empty. m_data and m_last show the head entry.
  - Pop when m_valid & m_ready; push and pop may happen in the same cycle.
  - Overflow is impossible by the credit rule; the verifier asserts it never occurs.
- m_valid, once asserted, holds with stable m_data and m_last until accepted.
- nent width is 5 bits, so at most 31 words per block. The i counter is 5 bits wide, compared against nent.
- A block that crosses address RAM_DEPTH-1 wraps to address 0.

Decomposition:
- Package mem_readout_pkg contains:
  - FSM state enum (IDLE, READ, DRAIN, DONE).
  - clogb2 function.
  - NENT_W=5 constant.
- One sub-module: readout_fifo, a synchronous FIFO with parameters WIDTH=RAM_WIDTH+1 and DEPTH, and ports push, pop, din, dout, empty, count.

Test Plan:
1. base_addr=0x010, nent=5, m_ready=1, BRAM preloaded mem[a]=a:
   - enb in cycles 1–5 with addrb 0x010..0x014.
   - m_data 0x010..0x014 in cycles 4–8, m_last in cycle 8.
   - done in cycle 9.
2. nent=0 → no enb and no m_valid; busy=1 in cycle 1, done=1 in cycle 1.
3. base_addr=0x3FE, nent=4 → addrb sequence 0x3FE, 0x3FF, 0x000, 0x001; data order preserved.
4. nent=8, m_ready low for cycles 4–12:
   - enb stops once fifo_count+inflight=4.
   - After m_ready rises, all 8 words arrive in order, no loss or duplication, m_last on word 8.
5. rstb asserted in cycle 3 of a nent=10 block:
   - Next cycle m_valid=0, busy=0, no done.
   - A fresh start for nent=2 then completes normally.
6. start pulsed again while busy (cycle 2 of a nent=6 block) → ignored; exactly 6 words and one done.
